// File: rtl/priority_dec_if.sv
// priority_dec_if
//   Handshake and output bundle for the priority decoder.
//   Y      [1:0] encoded index to decode
//   valid        Y is valid this cycle
//   ready        decoder can accept a transfer this cycle
//   D      [3:0] one-hot decoded line, zero when not driving
//   busy         decoder is in DRIVE or GAP
//   done         pulse on the last DRIVE cycle of each word
//   master: producer of Y/valid (consumer of the decoded outputs)
//   slave : the decoder itself
interface priority_dec_if;
  logic [1:0] Y;
  logic       valid;
  logic       ready;
  logic [3:0] D;
  logic       busy;
  logic       done;

  modport master (output Y, valid, input ready, D, busy, done);
  modport slave  (input Y, valid, output ready, D, busy, done);
endinterface

// File: rtl/priority_dec.sv
// priority_dec
//   Decodes a 2-bit index into a one-hot word held on D for HOLD cycles,
//   followed by GAP all-zero cycles. One word can be queued while busy.
//   Parameters: HOLD (1..255) drive cycles per word, GAP (0..255) zero cycles.
//   clk  sole clock, rising edge
//   rst  asynchronous, active-low reset
//   bus  priority_dec_if.slave (Y, valid in; ready, D, busy, done out)
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | nothing in flight, D=0, pending register always empty
// S_DRIVE | D holds the decoded word; cnt counts remaining drive cycles
// S_GAP   | D=0 spacing after a word; cnt counts remaining gap cycles
module priority_dec #(
  parameter int HOLD = 2,
  parameter int GAP  = 1
) (
  input  logic           clk,
  input  logic           rst,
  priority_dec_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_GAP} state_t;

  localparam logic [7:0] HOLD_C = 8'(HOLD);
  localparam logic [7:0] GAP_C  = 8'(GAP);

  state_t     state;
  logic [7:0] cnt;
  logic [1:0] pend;
  logic       pend_full;
  logic [3:0] d_q;
  logic       busy_q;
  logic       done_q;

  logic       xfer;
  logic       end_word;
  logic [1:0] launch_idx;

  function automatic logic [3:0] decode(input logic [1:0] idx);
    decode = 4'b1000 >> idx;
  endfunction

  // ready is forced low during reset, not just after the first edge
  assign bus.ready = rst & ~pend_full;
  assign xfer      = bus.valid & bus.ready;

  // Word boundary: last GAP cycle, or last DRIVE cycle when there is no gap.
  assign end_word  = ((state == S_DRIVE) && (cnt == 8'd1) && (GAP_C == 8'd0)) ||
                     ((state == S_GAP)   && (cnt == 8'd1));

  // A transfer landing exactly on the boundary launches directly instead of
  // passing through the pending register, so no cycle is lost.
  assign launch_idx = pend_full ? pend : bus.Y;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= 8'd0;
      pend      <= 2'd0;
      pend_full <= 1'b0;
      d_q       <= 4'b0000;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (xfer) begin
            state  <= S_DRIVE;
            d_q    <= decode(bus.Y);
            cnt    <= HOLD_C;
            busy_q <= 1'b1;
            done_q <= (HOLD_C == 8'd1);
          end
        end
        S_DRIVE, S_GAP: begin
          if (end_word) begin
            if (pend_full || xfer) begin
              state     <= S_DRIVE;
              d_q       <= decode(launch_idx);
              cnt       <= HOLD_C;
              done_q    <= (HOLD_C == 8'd1);
              pend_full <= 1'b0;
              pend      <= 2'd0;
            end else begin
              state  <= S_IDLE;
              d_q    <= 4'b0000;
              cnt    <= 8'd0;
              busy_q <= 1'b0;
              done_q <= 1'b0;
            end
          end else begin
            if (xfer) begin
              pend      <= bus.Y;
              pend_full <= 1'b1;
            end
            if ((state == S_DRIVE) && (cnt == 8'd1)) begin
              state  <= S_GAP;
              cnt    <= GAP_C;
              d_q    <= 4'b0000;
              done_q <= 1'b0;
            end else begin
              cnt <= cnt - 8'd1;
              if (state == S_DRIVE) done_q <= (cnt == 8'd2);
            end
          end
        end
        default: begin
          state  <= S_IDLE;
          d_q    <= 4'b0000;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.D    = d_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_priority_dec.sv
module tb_priority_dec;
  logic clk;
  logic rst;
  int   checks;
  int   fails;

  priority_dec_if bus_a ();
  priority_dec_if bus_b ();

  // bus_a: HOLD=2 GAP=1, bus_b: HOLD=1 GAP=0
  priority_dec #(.HOLD(2), .GAP(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  priority_dec #(.HOLD(1), .GAP(0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference priority encoder: highest set bit wins, bit 3 -> index 0.
  function automatic logic [1:0] encode(input logic [3:0] d);
    if (d[3])      encode = 2'd0;
    else if (d[2]) encode = 2'd1;
    else if (d[1]) encode = 2'd2;
    else           encode = 2'd3;
  endfunction

  // Advance one clock; inputs/outputs are handled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus_a.valid = 1'b0; bus_a.Y = 2'd0;
    bus_b.valid = 1'b0; bus_b.Y = 2'd0;
    #3;
    checks++;
    if ({bus_a.D, bus_a.busy, bus_a.done, bus_a.ready} !== 7'b0) begin
      fails++;
      $display("FAIL reset_a: got D=%b busy=%b done=%b ready=%b, want all 0",
               bus_a.D, bus_a.busy, bus_a.done, bus_a.ready);
    end
    checks++;
    if ({bus_b.D, bus_b.busy, bus_b.done, bus_b.ready} !== 7'b0) begin
      fails++;
      $display("FAIL reset_b: got D=%b busy=%b done=%b ready=%b, want all 0",
               bus_b.D, bus_b.busy, bus_b.done, bus_b.ready);
    end
    step();
    step();
    rst = 1'b1;
    step();
    checks++;
    if (bus_a.ready !== 1'b1 || bus_b.ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_ready: got a=%b b=%b, want 1 1", bus_a.ready, bus_b.ready);
    end
  endtask

  task automatic test_single();
    logic [3:0] exp_d    [1:4] = '{4'b0010, 4'b0010, 4'b0000, 4'b0000};
    logic       exp_done [1:4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic       exp_busy [1:4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    bus_a.Y = 2'd2; bus_a.valid = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      step();
      bus_a.valid = 1'b0;
      checks++;
      if (bus_a.D !== exp_d[c] || bus_a.done !== exp_done[c] || bus_a.busy !== exp_busy[c]) begin
        fails++;
        $display("FAIL single_c%0d: got D=%b done=%b busy=%b, want D=%b done=%b busy=%b",
                 c, bus_a.D, bus_a.done, bus_a.busy, exp_d[c], exp_done[c], exp_busy[c]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_d     [1:7] = '{4'b1000, 4'b1000, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
    logic       exp_ready [1:7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic       exp_done  [1:7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       exp_busy  [1:7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    bus_a.Y = 2'd0; bus_a.valid = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      step();
      if (c == 1) bus_a.Y = 2'd3;
      else        bus_a.valid = 1'b0;
      checks++;
      if (bus_a.D !== exp_d[c] || bus_a.ready !== exp_ready[c] ||
          bus_a.done !== exp_done[c] || bus_a.busy !== exp_busy[c]) begin
        fails++;
        $display("FAIL b2b_c%0d: got D=%b ready=%b done=%b busy=%b, want D=%b ready=%b done=%b busy=%b",
                 c, bus_a.D, bus_a.ready, bus_a.done, bus_a.busy,
                 exp_d[c], exp_ready[c], exp_done[c], exp_busy[c]);
      end
    end
  endtask

  task automatic test_backpressure();
    int accepts = 0;
    int acc_cyc = -1;
    int n0100 = 0;
    int windows = 0;
    int bad_onehot = 0;
    logic [3:0] prev_d = 4'b0000;
    bus_a.Y = 2'd2; bus_a.valid = 1'b1;
    step();
    bus_a.Y = 2'd3;
    step();
    bus_a.Y = 2'd1;
    for (int c = 2; c < 20; c++) begin
      if (bus_a.valid && bus_a.ready) begin
        accepts++;
        if (acc_cyc < 0) acc_cyc = c;
      end
      step();
      if (accepts != 0) bus_a.valid = 1'b0;
      if (bus_a.D == 4'b0100) n0100++;
      if (bus_a.D == 4'b0100 && prev_d != 4'b0100) windows++;
      if (bus_a.D != 4'b0000 && !$onehot(bus_a.D)) bad_onehot++;
      prev_d = bus_a.D;
    end
    bus_a.valid = 1'b0;
    checks++;
    if (accepts != 1 || acc_cyc != 4) begin
      fails++;
      $display("FAIL bp_accept: got accepts=%0d at cycle %0d, want 1 at cycle 4", accepts, acc_cyc);
    end
    checks++;
    if (n0100 != 2 || windows != 1) begin
      fails++;
      $display("FAIL bp_window: got %0d cycles in %0d windows of 0100, want 2 in 1", n0100, windows);
    end
    checks++;
    if (bad_onehot != 0 || bus_a.busy !== 1'b0) begin
      fails++;
      $display("FAIL bp_clean: got non-onehot=%0d busy=%b, want 0 0", bad_onehot, bus_a.busy);
    end
  endtask

  task automatic test_gap0();
    logic [3:0] exp_d [1:5] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0000};
    logic       exp_o [1:5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    bus_b.Y = 2'd0; bus_b.valid = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      step();
      if (c < 4) bus_b.Y = 2'(c);
      else       bus_b.valid = 1'b0;
      checks++;
      if (bus_b.D !== exp_d[c] || bus_b.done !== exp_o[c] || bus_b.busy !== exp_o[c] ||
          bus_b.ready !== 1'b1) begin
        fails++;
        $display("FAIL gap0_c%0d: got D=%b done=%b busy=%b ready=%b, want D=%b done=%b busy=%b ready=1",
                 c, bus_b.D, bus_b.done, bus_b.busy, bus_b.ready, exp_d[c], exp_o[c], exp_o[c]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int activity = 0;
    bus_a.Y = 2'd1; bus_a.valid = 1'b1;
    step();
    bus_a.Y = 2'd2;
    step();
    bus_a.valid = 1'b0;
    checks++;
    if (bus_a.D !== 4'b0100 || bus_a.ready !== 1'b0) begin
      fails++;
      $display("FAIL mid_pre: got D=%b ready=%b, want D=0100 ready=0", bus_a.D, bus_a.ready);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (bus_a.D !== 4'b0000 || bus_a.busy !== 1'b0 || bus_a.ready !== 1'b0 || bus_a.done !== 1'b0) begin
      fails++;
      $display("FAIL mid_async: got D=%b busy=%b ready=%b done=%b, want all 0",
               bus_a.D, bus_a.busy, bus_a.ready, bus_a.done);
    end
    #2 rst = 1'b1;
    step();
    checks++;
    if (bus_a.ready !== 1'b1) begin
      fails++;
      $display("FAIL mid_ready: got ready=%b, want 1", bus_a.ready);
    end
    for (int c = 0; c < 6; c++) begin
      if (bus_a.D != 4'b0000 || bus_a.busy != 1'b0) activity++;
      step();
    end
    checks++;
    if (activity != 0) begin
      fails++;
      $display("FAIL mid_residual: got %0d active cycles, want 0", activity);
    end
  endtask

  task automatic test_mapping();
    logic [3:0] exp_d [0:3] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    for (int y = 0; y < 4; y++) begin
      bus_a.Y = 2'(y); bus_a.valid = 1'b1;
      step();
      bus_a.valid = 1'b0;
      checks++;
      if (bus_a.D !== exp_d[y] || !$onehot(bus_a.D) || encode(bus_a.D) !== 2'(y)) begin
        fails++;
        $display("FAIL map_y%0d: got D=%b reencoded=%0d, want D=%b reencoded=%0d",
                 y, bus_a.D, encode(bus_a.D), exp_d[y], y);
      end
      step(); step(); step();
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_gap0();
    test_reset_mid();
    test_mapping();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/priority_dec.md
PRIORITY_DEC -- requirements
Module: priority_dec

Interface
REQ-001 Parameter HOLD, default 2, number of cycles each decoded one-hot word is driven on D; legal range 1..255.
REQ-002 Parameter GAP, default 1, number of all-zero cycles on D after each HOLD window; legal range 0..255.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset; asserted (0) forces the reset state immediately, independent of clk.
REQ-005 Y  input  2  encoded index to decode.
REQ-006 valid  input  1  Y is valid this cycle; a transfer occurs on a rising edge where valid=1 and ready=1.
REQ-007 ready  output  1  block can accept a transfer this cycle.
REQ-008 D  output  4  registered one-hot decoded line; all zero when not driving.
REQ-009 busy  output  1  registered; 1 while in DRIVE or GAP state.
REQ-010 done  output  1  registered one-cycle pulse marking the last DRIVE cycle of each word.

Function
REQ-011 Decode mapping SHALL be the exact inverse of the team's priority encoder: Y=0 -> D=4'b1000, Y=1 -> 4'b0100, Y=2 -> 4'b0010, Y=3 -> 4'b0001.
REQ-012 FSM SHALL have three states: IDLE, DRIVE, GAP.
REQ-013 Storage SHALL be a one-entry pending register plus a pend_full flag; ready SHALL equal !pend_full, and SHALL be 0 while rst=0.
REQ-014 IDLE: pend_full is always 0; a transfer at edge t SHALL load the index directly into the DRIVE path, so D shows the decoded word from cycle t+1, state DRIVE, HOLD counter loaded.
REQ-015 DRIVE: D SHALL hold the decoded word for exactly HOLD consecutive cycles; done=1 in the HOLD-th cycle only.
REQ-016 A transfer during DRIVE or GAP SHALL be stored in the pending register (pend_full<=1, ready drops the next cycle); no transfer is possible while pend_full=1.
REQ-017 End of DRIVE with GAP>0: next state GAP, D=0 for exactly GAP cycles.
REQ-018 End of GAP (or end of DRIVE when GAP=0): if pend_full=1, SHALL enter DRIVE with the pending index on the next cycle and clear pend_full in the same edge; else SHALL enter IDLE.
REQ-019 GAP=0 with a pending word: D SHALL switch directly from one one-hot value to the next with no zero cycle between them.
REQ-020 A transfer accepted on the same edge that GAP (or GAP=0 DRIVE) ends with pend_full=0 SHALL be treated as the pending word and launch immediately: no word is dropped and no extra idle cycle is inserted.
REQ-021 valid=1 with ready=0 SHALL have no effect; Y is never sampled without a transfer.
REQ-022 Counters SHALL be 8 bits wide; no wrap-around is permitted within the legal parameter range.
REQ-023 busy SHALL be 0 in IDLE and 1 in DRIVE and GAP; D SHALL be nonzero only in DRIVE and is always one-hot there.

Reset
REQ-024 rst=0 SHALL asynchronously set state=IDLE, D=4'b0000, busy=0, done=0, pend_full=0, counters=0, and the pending register to 0.
REQ-025 Reset asserted mid-DRIVE or mid-GAP SHALL abandon the current word and the pending word; after rst returns to 1, ready=1 on the first clock and no residual D activity occurs.

Verification (HOLD=2, GAP=1 unless stated)
REQ-026 Single word: transfer Y=2 at edge 0 -> D=0010 in cycles 1-2, done=1 in cycle 2, D=0 in cycle 3, IDLE and busy=0 from cycle 4.
REQ-027 Back-to-back: transfer Y=0 at edge 0 and Y=3 at edge 1 -> D=1000 in cycles 1-2, 0000 in cycle 3, 0001 in cycles 4-5; ready=0 in cycles 2-3.
REQ-028 Backpressure: with pend_full=1, hold valid=1 with Y=1 -> not accepted until ready=1, then accepted once; exactly one D=0100 window is produced.
REQ-029 GAP=0, HOLD=1: transfers Y=0, 1, 2, 3 on consecutive edges -> D sequence 1000, 0100, 0010, 0001 with no zero cycle, done=1 every cycle.
REQ-030 Reset mid-DRIVE: rst=0 asynchronously between edges -> D=0, busy=0, ready=0 immediately; after release, ready=1 and D stays 0 with no pending word launched.
REQ-031 Exhaustive mapping: all 4 Y values, each checked for one-hot D and for re-encoding through the priority encoder returning the original Y.
